fp_to_int_quant: RTL and testbench
==================================

Name: fp_to_int_quant

Overview:
- Streaming requantizer; converts FP results (default FP32) to signed INT_WIDTH integers, the inverse direction of the FP×INT multiplier datapath.
- Programmable power-of-two scale, RNE rounding, saturation.
- Sits at the accelerator output, ahead of the writer streamer, so FP32 accumulations can be stored as intN.
- 2-stage valid/ready pipeline.

Parameters:
- FpFormat_in, fpnew_pkg_versacore::fp_format_e'(0) (FP32): input format.
- INT_WIDTH, 8: output integer width, 2..16.
- WIDTH_IN, fp_width(FpFormat_in): derived, do not change.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- cfg_scale_exp_i  in  8  signed scale exponent; result is x·2^scale
- cfg_valid_i  in  1  load cfg_scale_exp_i into the scale register
- in_data_i  in  WIDTH_IN  FP operand
- in_valid_i  in  1  input valid
- in_ready_o  out  1  input ready
- out_data_o  out  INT_WIDTH  two's-complement result
- out_sat_o  out  1  result was clamped, or input was NaN/Inf
- out_valid_o  out  1  output valid
- out_ready_i  in  1  output ready

Behaviour:
- Reset: both stage valid bits = 0, scale register = 0, out_data_o = 0, out_sat_o = 0, out_valid_o = 0, in_ready_o = 1 after reset release.
- Reset mid-stream discards all in-flight data.
- Handshake: a transfer occurs when valid && ready.
- Stage n advances when it is empty or stage n+1 accepts.
- in_ready_o = !s1_valid || s1_advance, combinational from out_ready_i.
- Output data and flags hold stable while out_valid_o && !out_ready_i.
- Latency: 2 cycles from input acceptance to out_valid_o when not stalled. Throughput 1 per cycle. Buffering is 2 entries.
- Scale: the element sampled in stage 1 uses the register value current in its accept cycle. If cfg_valid_i and an input accept occur in the same cycle, the element uses the old scale.
- Stage 1: classify input (zero, subnormal, normal, inf, NaN).
  - Compute e = exp − BIAS + scale as a signed value of width EXP_BITS+2.
  - Register sign, 24-bit significand (with hidden bit), e, class.
- Stage 2: rounding and saturation.
  - Zero or subnormal input → 0, sat = 0 (subnormals flushed to zero).
  - NaN → 0, sat = 1. +Inf → 2^(N−1)−1, sat = 1. −Inf → −2^(N−1), sat = 1.
  - e ≤ −2 → 0 (magnitude < 0.5).
  - e ≥ N−1: positive → max, sat = 1. Negative → min; sat = 1 unless the value is exactly −2^(N−1) (significand == 1.0, e == N−1), in which case sat = 0.
  - Otherwise: magnitude = significand >> (MAN_BITS − e); guard = next bit, sticky = OR of the rest.
  - Round to nearest, ties to even.
  - If the rounded magnitude is 2^(N−1): positive → max with sat = 1; negative → min with sat = 0.
  - Negate if sign is set.
  - Exact −0.0 input → 0.

Optional Feature:
- Macro FP_TO_INT_QUANT_SAT_CNT_EN.
- Defined: adds output port sat_cnt_o (16 bits).
  - Counter increments on each output transfer with out_sat_o = 1 and saturates at 0xFFFF.
  - Cleared by reset and by cfg_valid_i.
  - If a clear and an increment occur in the same cycle, the clear wins.
- Undefined: the port and counter are absent; the rest of the behaviour is identical.

Decomposition:
- fpnew_pkg_versacore holds: fp_format_e, fp_width, exp_bits, man_bits, bias, and fp_info_t.
- Reuse fpnew_classifier for stage 1.
- One natural sub-module: fp_to_int_round_sat, the combinational stage-2 shift/RNE/saturate logic. It is the mirror of intN_to_fp16 and can be unit-tested alone.

Test Plan:
- Scale 0, INT8: 0x3FC00000 (1.5) → 2; 0x40200000 (2.5) → 2; 0xBF000000 (−0.5) → 0. All with sat = 0, each 2 cycles after accept.
- Saturation, INT8:
  - 0x43480000 (200.0) → 127, sat = 1.
  - 0xC3000000 (−128.0) → 0x80, sat = 0.
  - 0xC3010000 (−129.0) → 0x80, sat = 1.
  - 0x7FC00000 (NaN) → 0, sat = 1.
  - 0xFF800000 (−Inf) → 0x80, sat = 1.
- Scale and config timing: cfg 3 then 0x3F800000 (1.0) → 8. cfg −1 in the same cycle as accepting 0x40400000 (3.0) → 24, using old scale 3. The next 3.0 → 2 (1.5 rounded to even).
- Back-pressure: continuous stream 1..6 as FP32, out_ready_i low for cycles 3–7.
  - in_ready_o falls after 2 accepts.
  - Outputs 1..6 arrive in order with no loss or duplication.
  - Data stays stable during the stall.
- Reset: assert rst_i with both stages full. out_valid_o = 0 immediately (asynchronous). Scale reads 0 afterwards, and sat_cnt_o = 0 when FP_TO_INT_QUANT_SAT_CNT_EN is defined.
- With FP_TO_INT_QUANT_SAT_CNT_EN: send 3 saturating and 2 normal inputs → sat_cnt_o = 3. Then cfg_valid_i → 0.

Source files
------------

// File: rtl/fp_to_int_quant_pkg.sv
// Shared types for the FP-to-integer requantizer.
package fp_to_int_quant_pkg;

  // Operand class carried from stage 1 to stage 2.
  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_SUBNORM,
    CLS_NORMAL,
    CLS_INF,
    CLS_NAN
  } fp_class_e;

  localparam int unsigned SCALE_BITS   = 8;
  localparam int unsigned SAT_CNT_BITS = 16;

endpackage

// File: rtl/fpnew_pkg_versacore.sv
// Floating-point format descriptions shared by the FP datapath blocks.
package fpnew_pkg_versacore;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef struct packed {
    logic is_negative;
    logic is_normal;
    logic is_subnormal;
    logic is_zero;
    logic is_inf;
    logic is_nan;
    logic is_signalling;
    logic is_quiet;
    logic is_boxed;
  } fp_info_t;

  function automatic int unsigned exp_bits(input fp_format_e fmt);
    case (fmt)
      FP64:      return 11;
      FP16, FP8: return 5;
      default:   return 8;
    endcase
  endfunction

  function automatic int unsigned man_bits(input fp_format_e fmt);
    case (fmt)
      FP64:    return 52;
      FP16:    return 10;
      FP8:     return 2;
      FP16ALT: return 7;
      default: return 23;
    endcase
  endfunction

  function automatic int unsigned fp_width(input fp_format_e fmt);
    return 1 + exp_bits(fmt) + man_bits(fmt);
  endfunction

  function automatic int unsigned bias(input fp_format_e fmt);
    return (32'd1 << (exp_bits(fmt) - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/fp_to_int_round_sat.sv
// Combinational shift / round-to-nearest-even / saturate from a classified
// FP value (sign, significand with hidden bit, unbiased scaled exponent)
// to a signed INT_WIDTH integer.
module fp_to_int_round_sat
  import fp_to_int_quant_pkg::*;
#(
  parameter int unsigned MAN_BITS  = 23,
  parameter int unsigned EXP_BITS  = 8,
  parameter int unsigned INT_WIDTH = 8
) (
  input  logic                       sign_i,
  input  logic [MAN_BITS:0]          sig_i,
  input  logic signed [EXP_BITS+1:0] exp_i,
  input  fp_class_e                  cls_i,
  output logic [INT_WIDTH-1:0]       int_o,
  output logic                       sat_o
);

  // Significand placed above INT_WIDTH zero bits so every in-range shift
  // amount is at least 2 and guard/sticky always exist below the cut.
  localparam int unsigned EXT_W = MAN_BITS + INT_WIDTH + 2;

  logic [EXT_W-1:0]     ext;
  logic [INT_WIDTH-1:0] mag, mag_rnd, max_v, min_v;
  logic                 guard, sticky, rnd_up;
  int unsigned          sh;
  int                   e;

  // Magnitude extraction and RNE increment.
  always_comb begin
    e   = int'(exp_i);
    ext = {1'b0, sig_i, {INT_WIDTH{1'b0}}};
    sh  = MAN_BITS + 2;
    if (e >= -1 && e <= int'(INT_WIDTH) - 2) begin
      sh = unsigned'(int'(MAN_BITS + INT_WIDTH) - e);
    end
    mag     = INT_WIDTH'(ext >> sh);
    guard   = |(ext & (EXT_W'(1) << (sh - 1)));
    sticky  = |(ext & ~({EXT_W{1'b1}} << (sh - 1)));
    rnd_up  = guard & (sticky | mag[0]);
    mag_rnd = mag + {{(INT_WIDTH-1){1'b0}}, rnd_up};
  end

  // Class handling, range checks and final sign application.
  always_comb begin
    max_v = {1'b0, {(INT_WIDTH-1){1'b1}}};
    min_v = {1'b1, {(INT_WIDTH-1){1'b0}}};
    int_o = '0;
    sat_o = 1'b0;
    case (cls_i)
      CLS_NAN: sat_o = 1'b1;
      CLS_INF: begin
        int_o = sign_i ? min_v : max_v;
        sat_o = 1'b1;
      end
      CLS_NORMAL: begin
        if (e <= -2) begin
          int_o = '0;
        end else if (e >= int'(INT_WIDTH) - 1) begin
          int_o = sign_i ? min_v : max_v;
          sat_o = !sign_i ||
                  !(e == int'(INT_WIDTH) - 1 && sig_i == {1'b1, {MAN_BITS{1'b0}}});
        end else if (mag_rnd == min_v) begin
          // Rounded up to 2^(N-1): representable only when negative.
          int_o = sign_i ? min_v : max_v;
          sat_o = !sign_i;
        end else begin
          int_o = sign_i ? -mag_rnd : mag_rnd;
        end
      end
      default: int_o = '0;
    endcase
  end

endmodule

// File: rtl/fpnew_classifier.sv
// Combinational IEEE operand classifier (zero/subnormal/normal/inf/NaN).
module fpnew_classifier
  import fpnew_pkg_versacore::*;
#(
  parameter fp_format_e  FpFormat    = fp_format_e'(0),
  parameter int unsigned NumOperands = 1,
  localparam int unsigned WIDTH      = fp_width(FpFormat)
) (
  input  logic     [NumOperands-1:0][WIDTH-1:0] operands_i,
  input  logic     [NumOperands-1:0]            is_boxed_i,
  output fp_info_t [NumOperands-1:0]            info_o
);

  localparam int unsigned EXP_BITS = exp_bits(FpFormat);
  localparam int unsigned MAN_BITS = man_bits(FpFormat);

  for (genvar op = 0; op < NumOperands; op++) begin : gen_op
    logic                sign_w;
    logic [EXP_BITS-1:0] exp_w;
    logic [MAN_BITS-1:0] man_w;
    logic                exp_ones, exp_zero, man_zero;

    assign {sign_w, exp_w, man_w} = operands_i[op];
    assign exp_ones = &exp_w;
    assign exp_zero = ~|exp_w;
    assign man_zero = ~|man_w;

    assign info_o[op] = '{
      is_negative:   sign_w,
      is_normal:     is_boxed_i[op] & ~exp_ones & ~exp_zero,
      is_subnormal:  is_boxed_i[op] & exp_zero & ~man_zero,
      is_zero:       is_boxed_i[op] & exp_zero & man_zero,
      is_inf:        is_boxed_i[op] & exp_ones & man_zero,
      is_nan:        ~is_boxed_i[op] | (exp_ones & ~man_zero),
      is_signalling: is_boxed_i[op] & exp_ones & ~man_zero & ~man_w[MAN_BITS-1],
      is_quiet:      is_boxed_i[op] & exp_ones & ~man_zero & man_w[MAN_BITS-1],
      is_boxed:      is_boxed_i[op]
    };
  end

endmodule

// File: rtl/fp_to_int_quant.sv
// Streaming FP -> signed INT_WIDTH requantizer with power-of-two scale,
// RNE rounding and saturation; 2-stage valid/ready pipeline.
// Optional macro FP_TO_INT_QUANT_SAT_CNT_EN adds a saturating 16-bit
// count of saturated output transfers on sat_cnt_o.
module fp_to_int_quant
  import fpnew_pkg_versacore::*;
  import fp_to_int_quant_pkg::*;
#(
  parameter fp_format_e  FpFormat_in = fp_format_e'(0),
  parameter int unsigned INT_WIDTH   = 8,
  parameter int unsigned WIDTH_IN    = fp_width(FpFormat_in)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [7:0]           cfg_scale_exp_i,
  input  logic                 cfg_valid_i,
  input  logic [WIDTH_IN-1:0]  in_data_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic [INT_WIDTH-1:0] out_data_o,
  output logic                 out_sat_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i
`ifdef FP_TO_INT_QUANT_SAT_CNT_EN
  ,
  output logic [SAT_CNT_BITS-1:0] sat_cnt_o
`endif
);

  localparam int unsigned EXP_BITS = exp_bits(FpFormat_in);
  localparam int unsigned MAN_BITS = man_bits(FpFormat_in);
  localparam int unsigned BIAS     = bias(FpFormat_in);
  localparam int unsigned E_W      = EXP_BITS + 2;

  logic                         s2_ready, s1_accept;
  logic signed [SCALE_BITS-1:0] scale_q;
  fp_info_t [0:0]               info;

  logic                  s1_valid_q;
  logic                  s1_sign_q, s1_sign_d;
  logic [MAN_BITS:0]     s1_sig_q, s1_sig_d;
  logic signed [E_W-1:0] s1_e_q, s1_e_d;
  fp_class_e             s1_cls_q, s1_cls_d;

  logic                 out_valid_q, out_sat_q, rs_sat;
  logic [INT_WIDTH-1:0] out_data_q, rs_data;

  assign s2_ready    = !out_valid_q || out_ready_i;
  assign in_ready_o  = !s1_valid_q || s2_ready;
  assign s1_accept   = in_valid_i && in_ready_o;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_sat_o   = out_sat_q;

  fpnew_classifier #(
    .FpFormat    (FpFormat_in),
    .NumOperands (1)
  ) i_classifier (
    .operands_i (in_data_i),
    .is_boxed_i (1'b1),
    .info_o     (info)
  );

  // Stage-1 field extraction, scaled exponent and class decode.
  always_comb begin
    s1_sign_d = info[0].is_negative;
    s1_sig_d  = {info[0].is_normal, in_data_i[MAN_BITS-1:0]};
    s1_e_d    = E_W'(int'(in_data_i[WIDTH_IN-2 -: EXP_BITS]) - int'(BIAS) + int'(scale_q));
    if (info[0].is_nan || info[0].is_signalling || info[0].is_quiet || !info[0].is_boxed) begin
      s1_cls_d = CLS_NAN;
    end else if (info[0].is_inf) begin
      s1_cls_d = CLS_INF;
    end else if (info[0].is_zero) begin
      s1_cls_d = CLS_ZERO;
    end else if (info[0].is_subnormal) begin
      s1_cls_d = CLS_SUBNORM;
    end else begin
      s1_cls_d = CLS_NORMAL;
    end
  end

  // Scale register; an element accepted in the write cycle sees the old value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scale_q <= '0;
    end else if (cfg_valid_i) begin
      scale_q <= cfg_scale_exp_i;
    end
  end

  // Stage 1: capture classified operand on input accept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_sig_q   <= '0;
      s1_e_q     <= '0;
      s1_cls_q   <= CLS_ZERO;
    end else if (s1_accept) begin
      s1_valid_q <= 1'b1;
      s1_sign_q  <= s1_sign_d;
      s1_sig_q   <= s1_sig_d;
      s1_e_q     <= s1_e_d;
      s1_cls_q   <= s1_cls_d;
    end else if (s2_ready) begin
      s1_valid_q <= 1'b0;
    end
  end

  fp_to_int_round_sat #(
    .MAN_BITS  (MAN_BITS),
    .EXP_BITS  (EXP_BITS),
    .INT_WIDTH (INT_WIDTH)
  ) i_round_sat (
    .sign_i (s1_sign_q),
    .sig_i  (s1_sig_q),
    .exp_i  (s1_e_q),
    .cls_i  (s1_cls_q),
    .int_o  (rs_data),
    .sat_o  (rs_sat)
  );

  // Stage 2: registered output, held while the consumer stalls.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else if (s2_ready) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q <= rs_data;
        out_sat_q  <= rs_sat;
      end
    end
  end

`ifdef FP_TO_INT_QUANT_SAT_CNT_EN
  logic [SAT_CNT_BITS-1:0] sat_cnt_q;

  // Saturated-transfer counter; a cfg write clears it and wins over a count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sat_cnt_q <= '0;
    end else if (cfg_valid_i) begin
      sat_cnt_q <= '0;
    end else if (out_valid_q && out_ready_i && out_sat_q && sat_cnt_q != '1) begin
      sat_cnt_q <= sat_cnt_q + SAT_CNT_BITS'(1);
    end
  end

  assign sat_cnt_o = sat_cnt_q;
`endif

endmodule

// File: tb/tb_fp_to_int_quant.sv
// Self-checking bench for fp_to_int_quant (FP32 in, INT8 out).
module tb_fp_to_int_quant;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  cfg_scale_exp_i = '0;
  logic        cfg_valid_i = 1'b0;
  logic [31:0] in_data_i = '0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [7:0]  out_data_o;
  logic        out_sat_o;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
`ifdef FP_TO_INT_QUANT_SAT_CNT_EN
  logic [15:0] sat_cnt_o;
`endif

  int passed = 0;
  int total  = 0;
  int cur_scale = 0;

  fp_to_int_quant #(
    .INT_WIDTH (8)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .cfg_scale_exp_i (cfg_scale_exp_i),
    .cfg_valid_i     (cfg_valid_i),
    .in_data_i       (in_data_i),
    .in_valid_i      (in_valid_i),
    .in_ready_o      (in_ready_o),
    .out_data_o      (out_data_o),
    .out_sat_o       (out_sat_o),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i)
`ifdef FP_TO_INT_QUANT_SAT_CNT_EN
    ,
    .sat_cnt_o       (sat_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  // Reference: real-valued x*2^scale, RNE, clamp to int8.
  function automatic void ref_quant(input logic [31:0] b, input int scale,
                                    output logic [7:0] d, output logic s);
    int  ex, ri;
    real mag, fl, frac, r;
    d = '0;
    s = 1'b0;
    ex = int'(b[30:23]);
    if (ex == 255) begin
      if (b[22:0] != 0) s = 1'b1;
      else begin d = b[31] ? 8'h80 : 8'h7f; s = 1'b1; end
      return;
    end
    if (ex == 0) return;
    mag = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** real'(ex - 127 + scale));
    if (mag >= 128.0) begin
      d = b[31] ? 8'h80 : 8'h7f;
      s = b[31] ? (mag != 128.0) : 1'b1;
      return;
    end
    fl   = $floor(mag);
    frac = mag - fl;
    if (frac > 0.5 || (frac == 0.5 && (int'(fl) % 2) == 1)) r = fl + 1.0;
    else r = fl;
    if (r >= 128.0) begin
      d = b[31] ? 8'h80 : 8'h7f;
      s = !b[31];
      return;
    end
    ri = int'(r);
    d  = b[31] ? 8'(-ri) : 8'(ri);
  endfunction

  function automatic logic [31:0] int_to_fp32(input int k);
    int          e;
    logic [31:0] m;
    e = $clog2(k + 1) - 1;
    m = 32'(k) << (23 - e);
    return {1'b0, 8'(e + 127), m[22:0]};
  endfunction

  task automatic cfg(input int s);
    cfg_scale_exp_i = 8'(s);
    cfg_valid_i = 1'b1;
    cycle();
    cfg_valid_i = 1'b0;
    cur_scale = s;
  endtask

  // Sends one element and collects its result; lat = cycles from accept, -1 on timeout.
  task automatic xfer(input logic [31:0] bits, output logic [7:0] d, output logic s, output int lat);
    int w;
    d = '0; s = 1'b0; lat = -1;
    in_data_i = bits;
    in_valid_i = 1'b1;
    w = 0;
    while (!in_ready_o && w < 20) begin cycle(); w++; end
    cycle();
    in_valid_i = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (out_valid_o) begin
        d = out_data_o; s = out_sat_o; lat = i;
        cycle();
        return;
      end
      cycle();
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk_i);
    #1;
    total++; if (out_valid_o !== 1'b0) $display("FAIL reset_valid_in_reset got=%b exp=0", out_valid_o); else passed++;
    rst_i = 1'b0;
    cycle();
    total++; if (out_valid_o !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid_o); else passed++;
    total++; if (out_data_o !== 8'h00) $display("FAIL reset_out_data got=%h exp=00", out_data_o); else passed++;
    total++; if (out_sat_o !== 1'b0) $display("FAIL reset_out_sat got=%b exp=0", out_sat_o); else passed++;
    total++; if (in_ready_o !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready_o); else passed++;
`ifdef FP_TO_INT_QUANT_SAT_CNT_EN
    total++; if (sat_cnt_o !== 16'd0) $display("FAIL reset_sat_cnt got=%0d exp=0", sat_cnt_o); else passed++;
`endif
  endtask

  task automatic test_basic();
    logic [31:0] vin [4] = '{32'h3FC00000, 32'h40200000, 32'hBF000000, 32'h40600000};
    logic [7:0]  vexp[4] = '{8'd2, 8'd2, 8'd0, 8'd4};
    logic [7:0]  d; logic s; int lat;
    for (int i = 0; i < 4; i++) begin
      xfer(vin[i], d, s, lat);
      total++; if (d !== vexp[i]) $display("FAIL basic_data[%0d] in=%h got=%h exp=%h", i, vin[i], d, vexp[i]); else passed++;
      total++; if (s !== 1'b0) $display("FAIL basic_sat[%0d] got=%b exp=0", i, s); else passed++;
      total++; if (lat !== 2) $display("FAIL basic_latency[%0d] got=%0d exp=2", i, lat); else passed++;
    end
  endtask

  task automatic test_saturation();
    logic [31:0] vin [6] = '{32'h43480000, 32'hC3000000, 32'hC3010000, 32'h7FC00000, 32'hFF800000, 32'h80000000};
    logic [7:0]  vexp[6] = '{8'h7F, 8'h80, 8'h80, 8'h00, 8'h80, 8'h00};
    logic        sexp[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0]  d; logic s; int lat;
    for (int i = 0; i < 6; i++) begin
      xfer(vin[i], d, s, lat);
      total++; if (d !== vexp[i]) $display("FAIL sat_data[%0d] in=%h got=%h exp=%h", i, vin[i], d, vexp[i]); else passed++;
      total++; if (s !== sexp[i]) $display("FAIL sat_flag[%0d] in=%h got=%b exp=%b", i, vin[i], s, sexp[i]); else passed++;
    end
  endtask

  task automatic test_scale_timing();
    logic [7:0] d; logic s; int lat;
    cfg(3);
    xfer(32'h3F800000, d, s, lat);
    total++; if (d !== 8'd8) $display("FAIL scale3_one got=%0d exp=8", d); else passed++;
    cfg_scale_exp_i = 8'hFF;
    cfg_valid_i = 1'b1;
    in_data_i = 32'h40400000;
    in_valid_i = 1'b1;
    #1;
    total++; if (in_ready_o !== 1'b1) $display("FAIL same_cycle_ready got=%b exp=1", in_ready_o); else passed++;
    @(posedge clk_i); #1;
    cfg_valid_i = 1'b0;
    in_valid_i = 1'b0;
    cur_scale = -1;
    lat = -1; d = '0;
    for (int i = 1; i <= 20; i++) begin
      if (out_valid_o) begin d = out_data_o; lat = i; break; end
      cycle();
    end
    cycle();
    total++; if (d !== 8'd24) $display("FAIL same_cycle_old_scale got=%0d exp=24", d); else passed++;
    total++; if (lat !== 2) $display("FAIL same_cycle_latency got=%0d exp=2", lat); else passed++;
    xfer(32'h40400000, d, s, lat);
    total++; if (d !== 8'd2) $display("FAIL new_scale_tie got=%0d exp=2", d); else passed++;
    cfg(0);
  endtask

  task automatic test_random();
    logic [31:0] b; logic [7:0] d, ed; logic s, es; int lat, ex;
    for (int i = 0; i < 60; i++) begin
      if (i % 8 == 0) cfg(int'($urandom_range(8, 0)) - 4);
      ex = 118 + int'($urandom_range(24, 0));
      if (i % 10 == 9) ex = ($urandom_range(1, 0) != 0) ? 255 : 0;
      b = {1'($urandom_range(1, 0)), 8'(ex), 23'($urandom)};
      ref_quant(b, cur_scale, ed, es);
      xfer(b, d, s, lat);
      total++; if (d !== ed) $display("FAIL rand_data[%0d] in=%h scale=%0d got=%h exp=%h", i, b, cur_scale, d, ed); else passed++;
      total++; if (s !== es) $display("FAIL rand_sat[%0d] in=%h scale=%0d got=%b exp=%b", i, b, cur_scale, s, es); else passed++;
    end
    cfg(0);
  endtask

  task automatic test_back_to_back();
    int sent, got;
    logic [7:0] pd; logic ps, pstall;
    sent = 0; got = 0; pstall = 1'b0; pd = '0; ps = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      out_ready_i = !(cyc >= 3 && cyc <= 7);
      in_valid_i  = (sent < 6);
      in_data_i   = int_to_fp32(sent + 1);
      #1;
      if (pstall) begin
        total++;
        if (out_valid_o !== 1'b1 || out_data_o !== pd || out_sat_o !== ps)
          $display("FAIL b2b_stall_stable cyc=%0d got=%b/%h/%b exp=1/%h/%b", cyc, out_valid_o, out_data_o, out_sat_o, pd, ps);
        else passed++;
      end
      if (cyc == 6) begin
        total++; if (in_ready_o !== 1'b0) $display("FAIL b2b_ready_low got=%b exp=0", in_ready_o); else passed++;
        total++; if (sent - got !== 2) $display("FAIL b2b_buffered got=%0d exp=2", sent - got); else passed++;
      end
      if (out_valid_o && out_ready_i) begin
        total++;
        if (out_data_o !== 8'(got + 1) || out_sat_o !== 1'b0)
          $display("FAIL b2b_order idx=%0d got=%h/%b exp=%h/0", got, out_data_o, out_sat_o, 8'(got + 1));
        else passed++;
        got++;
      end
      pstall = out_valid_o && !out_ready_i;
      pd = out_data_o;
      ps = out_sat_o;
      if (in_valid_i && in_ready_o) sent++;
      @(posedge clk_i); #1;
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    total++; if (got !== 6) $display("FAIL b2b_count got=%0d exp=6", got); else passed++;
  endtask

  task automatic test_reset_midstream();
    logic [7:0] d; logic s; int lat;
    cfg(3);
    out_ready_i = 1'b0;
    in_data_i = 32'h3F800000;
    in_valid_i = 1'b1;
    cycle();
    cycle();
    in_valid_i = 1'b0;
    total++; if (out_valid_o !== 1'b1 || in_ready_o !== 1'b0) $display("FAIL mid_full got=%b/%b exp=1/0", out_valid_o, in_ready_o); else passed++;
    #2;
    rst_i = 1'b1;
    #1;
    total++; if (out_valid_o !== 1'b0) $display("FAIL mid_async_clear got=%b exp=0", out_valid_o); else passed++;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    out_ready_i = 1'b1;
    cur_scale = 0;
    cycle();
    total++; if (out_valid_o !== 1'b0) $display("FAIL mid_no_stale got=%b exp=0", out_valid_o); else passed++;
`ifdef FP_TO_INT_QUANT_SAT_CNT_EN
    total++; if (sat_cnt_o !== 16'd0) $display("FAIL mid_sat_cnt got=%0d exp=0", sat_cnt_o); else passed++;
`endif
    xfer(32'h3F800000, d, s, lat);
    total++; if (d !== 8'd1) $display("FAIL mid_scale_reset got=%0d exp=1", d); else passed++;
  endtask

`ifdef FP_TO_INT_QUANT_SAT_CNT_EN
  task automatic test_sat_cnt();
    logic [31:0] vin[5] = '{32'h43480000, 32'h3F800000, 32'h7FC00000, 32'h40000000, 32'hFF800000};
    logic [7:0] d; logic s; int lat;
    cfg(0);
    for (int i = 0; i < 5; i++) xfer(vin[i], d, s, lat);
    total++; if (sat_cnt_o !== 16'd3) $display("FAIL sat_cnt_count got=%0d exp=3", sat_cnt_o); else passed++;
    cfg(0);
    total++; if (sat_cnt_o !== 16'd0) $display("FAIL sat_cnt_clear got=%0d exp=0", sat_cnt_o); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_scale_timing();
    test_random();
    test_back_to_back();
    test_reset_midstream();
`ifdef FP_TO_INT_QUANT_SAT_CNT_EN
    test_sat_cnt();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
